// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/valid handshake, instruction register and decoded fields.
// Optional misaligned-branch trap enabled by defining ALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_s,
  output logic [31:0] imem_addr_s,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        pcSrc_s,
  input  logic [31:0] pcTarget_s,
  output logic [31:0] instr_s,
  output logic [6:0]  opcode_s,
  output logic [2:0]  f3_s,
  output logic        f7_5_s,
  output logic [4:0]  rd_s,
  output logic [4:0]  rs1_s,
  output logic [4:0]  rs2_s,
  output logic [31:0] pc_s,
  output logic [31:0] pcPlus4_s,
  output logic        instr_valid_s,
  output logic        trap_s
);

`ifdef ALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1, TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1} state_t;
`endif

  state_t      stateReg;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic        reqReg;
  logic        validReg;
  logic [31:0] pcPlus4;
  logic [31:0] targetNext;

  assign pcPlus4 = pcReg + 32'd4;

`ifdef ALIGN_TRAP_EN
  logic trapReg;
  logic misaligned;
  assign targetNext = pcTarget_s;
  assign misaligned = pcSrc_s && (pcTarget_s[1:0] != 2'b00);
  assign trap_s     = trapReg;
`else
  // Without the trap, a misaligned target is silently word-aligned.
  assign targetNext = pcTarget_s & 32'hFFFF_FFFC;
  assign trap_s     = 1'b0;
`endif

  // reqReg stays low in the partial cycle after reset release, so imem_valid
  // is only accepted once a request is actually on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= FETCH;
      pcReg    <= RESET_PC;
      instrReg <= NOP_INSTR;
      reqReg   <= 1'b0;
      validReg <= 1'b0;
`ifdef ALIGN_TRAP_EN
      trapReg  <= 1'b0;
`endif
    end else begin
      case (stateReg)
        FETCH: begin
          if (reqReg && imem_valid) begin
            instrReg <= imem_rdata;
            reqReg   <= 1'b0;
            validReg <= 1'b1;
            stateReg <= ISSUE;
          end else begin
            reqReg <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
`ifdef ALIGN_TRAP_EN
            if (misaligned) begin
              validReg <= 1'b0;
              trapReg  <= 1'b1;
              stateReg <= TRAP;
            end else
`endif
            begin
              pcReg    <= pcSrc_s ? targetNext : pcPlus4;
              reqReg   <= 1'b1;
              validReg <= 1'b0;
              stateReg <= FETCH;
            end
          end
        end
`ifdef ALIGN_TRAP_EN
        TRAP: begin
          reqReg   <= 1'b0;
          validReg <= 1'b0;
          trapReg  <= 1'b1;
        end
`endif
        default: stateReg <= FETCH;
      endcase
    end
  end

  assign imem_req_s    = reqReg;
  assign imem_addr_s   = pcReg;
  assign instr_valid_s = validReg;
  assign instr_s       = instrReg;
  assign pc_s          = pcReg;
  assign pcPlus4_s     = pcPlus4;

  assign opcode_s = instrReg[6:0];
  assign rd_s     = instrReg[11:7];
  assign f3_s     = instrReg[14:12];
  assign rs1_s    = instrReg[19:15];
  assign rs2_s    = instrReg[24:20];
  assign f7_5_s   = instrReg[30];

endmodule
